// File: rtl/uart_pkg.sv
// Shared UART receive definitions.
// FSM state encoding, sample-point helpers and data-width limits.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } rx_state_e;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;

  // Three mid-bit sample points around the centre of a bit.
  function automatic int smp_lo(input int os);
    return os / 2 - 1;
  endfunction

  function automatic int smp_mid(input int os);
    return os / 2;
  endfunction

  function automatic int smp_hi(input int os);
    return os / 2 + 1;
  endfunction

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx pad.
// Resets to the idle-high line level.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the pad level through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '1;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start/data/stop deserializer
// with a one-deep valid/ready holding register.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_LO   = TW'(smp_lo(OVERSAMPLE));
  localparam logic [TW-1:0] T_MID  = TW'(smp_mid(OVERSAMPLE));
  localparam logic [TW-1:0] T_HI   = TW'(smp_hi(OVERSAMPLE));
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  rx_state_e             state;
  logic [TW-1:0]         tcnt;
  logic [BW-1:0]         bcnt;
  logic [2:0]            smp;
  logic [DATA_BITS-1:0]  shreg;
  logic                  rx_s;
  logic                  bit_maj;
  logic                  stop_maj;
  logic                  stop_tick;
  logic                  frame_ok;

  uart_rx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  // The stop decision is taken on the third sample tick itself,
  // so the live rx_s stands in for the not-yet-registered sample.
  assign bit_maj   = maj3(smp[0], smp[1], smp[2]);
  assign stop_maj  = maj3(smp[0], smp[1], rx_s);
  assign stop_tick = (state == STOP) && baud_tick && (tcnt == T_HI);
  assign frame_ok  = enable && stop_tick && stop_maj;
  assign busy      = (state != IDLE);

  // Receive FSM: start validation, data shift, stop check, break wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tcnt          <= '0;
      bcnt          <= '0;
      smp           <= '0;
      shreg         <= '0;
      framing_error <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        tcnt  <= '0;
        bcnt  <= '0;
      end else if (baud_tick) begin
        if (state != IDLE) begin
          if (tcnt == T_LO)  smp[0] <= rx_s;
          if (tcnt == T_MID) smp[1] <= rx_s;
          if (tcnt == T_HI)  smp[2] <= rx_s;
        end
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              tcnt  <= TW'(1);
            end
          end
          START: begin
            if (tcnt == T_LAST) begin
              tcnt  <= '0;
              bcnt  <= '0;
              state <= bit_maj ? IDLE : DATA;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          DATA: begin
            if (tcnt == T_LAST) begin
              tcnt  <= '0;
              shreg <= {bit_maj, shreg[DATA_BITS-1:1]};
              if (bcnt == B_LAST) begin
                state <= STOP;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          STOP: begin
            if (tcnt == T_HI) begin
              tcnt <= '0;
              if (stop_maj) begin
                state <= IDLE;
              end else begin
                framing_error <= 1'b1;
                state         <= BREAK_WAIT;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          BREAK_WAIT: begin
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Holding register: accept/clear handshake and overrun on a full slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (frame_ok) begin
        if (!m_valid || m_ready) begin
          m_data  <= shreg;
          m_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core.
// Baud tick every 4 clk, so one bit lasts 64 clk.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic       busy;
  logic       framing_error;
  logic       overrun;

  int         checks = 0;
  int         errors = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         cyc = 0;
  int         last_acc = 0;
  int         t0;
  logic [1:0] div = 2'd0;
  logic [7:0] exp_q[$];

  uart_rx_core #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .baud_tick    (baud_tick),
    .rx           (rx),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .busy         (busy),
    .framing_error(framing_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    div       <= div + 2'd1;
    baud_tick <= (div == 2'd3);
  end

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic b, input int n);
    step();
    rx = b;
    repeat (n - 1) step();
  endtask

  task automatic send(
    input logic [7:0] d,
    input logic       stop_lvl,
    input int         stop_len
  );
    drive(1'b0, 64);
    for (int i = 0; i < 8; i++) drive(d[i], 64);
    drive(stop_lvl, stop_len);
  endtask

  task automatic monitor();
    logic [7:0] pd;
    logic       pv;
    logic       pr;
    logic [7:0] e;
    pv = 1'b0;
    pr = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (framing_error) fe_cnt++;
        if (overrun) ov_cnt++;
        if (pv && !pr && m_valid) chk("hold_stable", m_data, pd);
        if (m_valid && m_ready) begin
          last_acc = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rx_data", m_data, e);
          end
        end
        pv = m_valid;
        pr = m_ready;
        pd = m_data;
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (4) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", m_data, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fe", framing_error, 0);
    chk("rst_ov", overrun, 0);
    drive(1'b1, 64);

    // 1: plain frame, latency around 9.5 bit times
    fe_cnt = 0;
    ov_cnt = 0;
    exp_q.push_back(8'hA5);
    t0 = cyc + 1;
    send(8'hA5, 1'b1, 64);
    drive(1'b1, 32);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_latency", int'((last_acc - t0) >= 600 && (last_acc - t0) <= 630), 1);
    chk("t1_fe", fe_cnt, 0);
    chk("t1_ov", ov_cnt, 0);

    // 2: short glitch rejected
    drive(1'b0, 12);
    drive(1'b1, 80);
    chk("t2_busy", busy, 0);
    chk("t2_fe", fe_cnt, 0);
    chk("t2_ov", ov_cnt, 0);

    // 3: stop bit held low -> framing error, wait for line high
    send(8'h3C, 1'b0, 128);
    chk("t3_busy_break", busy, 1);
    chk("t3_valid", m_valid, 0);
    drive(1'b1, 24);
    chk("t3_busy_idle", busy, 0);
    chk("t3_fe", fe_cnt, 1);
    chk("t3_ov", ov_cnt, 0);
    drive(1'b1, 40);

    // 4: full holding register -> overrun
    fe_cnt = 0;
    step();
    m_ready = 1'b0;
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1, 64);
    drive(1'b1, 32);
    send(8'h22, 1'b1, 64);
    drive(1'b1, 32);
    chk("t4_valid", m_valid, 1);
    chk("t4_data", m_data, 8'h11);
    chk("t4_ov", ov_cnt, 1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    step();
    @(negedge clk);
    chk("t4_valid_clr", m_valid, 0);
    chk("t4_drained", exp_q.size(), 0);
    step();
    m_ready = 1'b1;

    // 5: back-to-back frames
    ov_cnt = 0;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send(8'h55, 1'b1, 64);
    send(8'hAA, 1'b1, 64);
    drive(1'b1, 64);
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_data", m_data, 8'hAA);
    chk("t5_fe", fe_cnt, 0);
    chk("t5_ov", ov_cnt, 0);

    // 6: reset during data bit 3, then a clean frame
    drive(1'b0, 64);
    drive(1'b1, 64);
    drive(1'b0, 64);
    drive(1'b1, 64);
    drive(1'b0, 32);
    chk("t6_busy_pre", busy, 1);
    step();
    rst = 1'b1;
    rx  = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_data", m_data, 0);
    chk("t6_valid", m_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_fe", framing_error, 0);
    chk("t6_ov", overrun, 0);
    drive(1'b1, 64);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1, 64);
    drive(1'b1, 64);
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_rx_data", m_data, 8'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receive path that consumes the 16x oversample tick from uart_baud_gen and deserializes an asynchronous rx line into data words. It does start-bit validation, majority-vote mid-bit sampling, stop-bit checking, and provides a one-deep holding register with a valid/ready handshake toward the FIFO/register interface. It is the receive-side counterpart of the tick producer and sits between the pad-side rx line and the UART host registers.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, baud ticks per bit period (power of two, >=8)
SYNC_STAGES, 2, rx input synchronizer depth (>=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
enable  input  1  receiver enable; low forces FSM to IDLE
baud_tick  input  1  single-cycle oversample strobe from uart_baud_gen
rx  input  1  asynchronous serial input, idle high
m_data  output  DATA_BITS  received word
m_valid  output  1  m_data holds an unconsumed word
m_ready  input  1  consumer accepts m_data when m_valid && m_ready
busy  output  1  high in any state other than IDLE
framing_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: frame completed while holding register full and not being drained

Behaviour:
- Reset (rst=1 at posedge clk): m_data=0, m_valid=0, busy=0, framing_error=0, overrun=0, FSM=IDLE, tick counter=0, bit counter=0, all synchronizer flops=1. Reset mid-frame abandons the frame with no pulses.
- rx passes through SYNC_STAGES flops; all decisions use the synchronized value rx_s.
- FSM advances only on cycles with baud_tick=1, except for the handshake and enable logic.
- Tick counter tcnt counts 0..OVERSAMPLE-1 within each bit. Samples are taken at tcnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority.
- IDLE: on a tick with rx_s=0, go to START with tcnt=1 (the detecting tick counts as 0).
- START: at the tcnt=OVERSAMPLE-1 tick, evaluate the majority. If 0, go to DATA with bit counter=0. If 1, treat it as a glitch and return to IDLE with no pulse.
- DATA: at each tcnt=OVERSAMPLE-1 tick, shift the majority into a shift register LSB-first. After DATA_BITS bits, go to STOP.
- STOP: the decision is made at the tick with tcnt=OVERSAMPLE/2+1, i.e. mid-stop, so a start bit that follows immediately is not missed.
  - Majority 1: frame good; deliver the word. Return to IDLE.
  - Majority 0: framing_error pulses the next cycle and the word is discarded. Go to BREAK_WAIT.
- BREAK_WAIT: stay until a tick with rx_s=1, then go to IDLE. This handles a line break.
- Delivery, taking effect on the cycle after the deciding tick:
  - If m_valid=0, or m_ready=1 in that same cycle: load m_data and set m_valid=1.
  - Otherwise: keep the old m_data, drop the new word, and pulse overrun for 1 cycle.
- Handshake: m_valid clears on the cycle after m_valid && m_ready unless a new word loads in that same cycle. m_data is stable while m_valid=1 and not accepted.
- enable=0: the FSM goes to IDLE on the next clk and discards any partial frame. The holding register and handshake keep working. The synchronizer still runs.
- baud_tick while rst=1 is ignored. Counters wrap only through explicit state transitions; no free-running wrap.

Decomposition:
- Shared package uart_pkg holds:
  - the rx FSM state enum (IDLE, START, DATA, STOP, BREAK_WAIT);
  - OVERSAMPLE default and the derived sample-point constants;
  - the DATA_BITS limits.
- One natural sub-module, uart_rx_sync: a SYNC_STAGES-deep synchronizer with reset-to-1.
- Majority vote and holding register stay inline.

Test Plan:
Bench setup: uart_baud_gen at divisor=4, giving baud_tick every 4 clk, so one bit = 64 clk.
1. m_ready=1; send 0xA5, 8N1 -> exactly one m_valid pulse with m_data=0xA5, about 9.5 bit times (~608 clk) after the start edge; framing_error=0, overrun=0.
2. rx low for 3 ticks (12 clk), then high -> no m_valid, busy returns to 0 within 16 ticks, no pulses.
3. Send 0x3C with stop bit driven 0 for 2 bit times -> framing_error one-cycle pulse, m_valid stays 0, busy stays 1 until rx returns high.
4. m_ready=0; send 0x11 then 0x22 -> m_data=0x11 held with m_valid=1, overrun pulses once at end of the second frame; then m_ready=1 for one cycle -> m_valid=0.
5. m_ready=1; send 0x55 and 0xAA back-to-back with zero idle between stop and start -> two valid words 0x55, 0xAA, no errors.
6. Assert rst for 1 cycle during data bit 3 of a frame -> all outputs 0 next cycle. After rx is idle high for one bit time, send 0x81 -> m_data=0x81 received correctly.
